key_debounce_multi: RTL and testbench
=====================================

# key_debounce_multi

N-channel, parametrised key conditioner: synchronises raw active-low push-button inputs, debounces them, and emits a clean level plus single-cycle press, release and long-press events per channel. It sits between the board key pins and the MNIST top-level control logic, which today handles a single key. It lets further buttons (start inference, next image, UART resend, mode) be added without each consumer carrying its own debounce logic.

## Interface
- `NUM_KEYS`, 4: number of independent key channels (≥1).
- `DB_CYCLES`, 1_000_000: stable-sample count required to accept a change (20 ms @ 50 MHz); ≥2.
- `LONG_CYCLES`, 50_000_000: cycles from accepted press to long-press event (1 s @ 50 MHz); must be > `DB_CYCLES`.
- `clk`  in  1  system clock, 50 MHz nominal.
- `rst_n`  in  1  asynchronous active-low reset.
- `key_n`  in  NUM_KEYS  raw keys, active-low, asynchronous to `clk`, idle high.
- `key_level`  out  NUM_KEYS  debounced state, 1 = pressed.
- `press_pulse`  out  NUM_KEYS  one-cycle pulse on accepted press.
- `release_pulse`  out  NUM_KEYS  one-cycle pulse on accepted release.
- `long_pulse`  out  NUM_KEYS  one-cycle pulse when press held `LONG_CYCLES`.
- `key_any`  out  1  OR of `key_level`, registered.

## Operation
- Per channel: 2-flop synchroniser (flops reset to 1), then FSM with debounce counter of width $clog2(DB_CYCLES).
- IDLE: level 0; sync=0 → PRESS_WAIT, cnt←0.
- PRESS_WAIT: sync=1 → IDLE (bounce rejected, no event); else cnt++; at cnt==DB_CYCLES-1 with sync=0 → DOWN, `press_pulse`=1, `key_level`←1.
- DOWN: sync=1 → RELEASE_WAIT, cnt←0.
- RELEASE_WAIT: sync=0 → DOWN (no event); else cnt++; at cnt==DB_CYCLES-1 with sync=1 → IDLE, `release_pulse`=1, `key_level`←0.
- Long counter (width $clog2(LONG_CYCLES+1)): cleared on entering DOWN from PRESS_WAIT; increments in DOWN and RELEASE_WAIT; saturates. `long_pulse` fires once when it reaches LONG_CYCLES-1. No auto-repeat. Cleared on entering IDLE.
- A release accepted before LONG_CYCLES yields no `long_pulse`.
- Channels fully independent; simultaneous events on several channels are all reported in the same cycle.

## Timing
- All outputs registered; reset value of every output 0; all FSMs in IDLE.
- Press latency: `key_n` low sampled at edge k → `press_pulse` high for exactly the cycle following edge k+DB_CYCLES+2. Release latency identical.
- `long_pulse` asserts LONG_CYCLES cycles after `press_pulse`.
- `key_any` lags `key_level` by one cycle.
- Reset mid-operation: counters and FSMs clear immediately. If a key is still held when reset is released, a full press sequence follows (`press_pulse` after DB_CYCLES+2 cycles). No spurious release is generated.
- `press_pulse` and `release_pulse` of one channel are never high together. A minimum of DB_CYCLES cycles separates them.

## Configuration
- `KEY_LONG_PRESS_EN` defined: long counter and `long_pulse` logic built as above.
- Undefined: long counters removed, `long_pulse` tied to 0. All other behaviour is unchanged.

## Test plan
Bench params: NUM_KEYS=2, DB_CYCLES=4, LONG_CYCLES=16, 20 ns clock, `KEY_LONG_PRESS_EN` defined unless stated.
- Clean press of key0 (low for 10 cycles) → `press_pulse[0]` one cycle, 6 cycles after first low sample; `key_level[0]`=1; `release_pulse[0]` 6 cycles after return high; no `long_pulse`.
- Bounce: key0 low 2 cycles, high 1, low 2, high → no events, `key_level`=0 throughout.
- Hold key1 low 30 cycles → `press_pulse[1]`, then `long_pulse[1]` exactly 16 cycles later, once only; release gives `release_pulse[1]`.
- Both keys pressed on the same edge → both `press_pulse` bits in the same cycle; `key_any` high one cycle after.
- Assert `rst_n` low for 1 cycle while key0 held and `key_level[0]`=1 → all outputs 0 immediately; `press_pulse[0]` 6 cycles after reset release.
- Rebuild without `KEY_LONG_PRESS_EN` and hold 30 cycles → `long_pulse` stays 0; press and release identical to the first scenario.

Source files
------------

// File: rtl/key_debounce_multi.sv
// N-channel push-button conditioner: 2-flop sync, debounce FSM, press/release/long-press pulses.
// Define KEY_LONG_PRESS_EN to build the long-press counters; otherwise long_pulse is tied low.

module key_debounce_chan #(
  parameter int DB_CYCLES   = 4
`ifdef KEY_LONG_PRESS_EN
  , parameter int LONG_CYCLES = 16
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  localparam logic [1:0] S_IDLE         = 2'd0;
  localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] S_DOWN         = 2'd2;
  localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

  logic             sync_meta;
  logic             sync_key;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             accept_press;
  logic             accept_release;

  // Synchroniser idles high so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b1;
      sync_key  <= 1'b1;
    end else begin
      sync_meta <= key_n;
      sync_key  <= sync_meta;
    end
  end

  assign accept_press   = (state == S_PRESS_WAIT)   && !sync_key && (cnt == CNT_LAST);
  assign accept_release = (state == S_RELEASE_WAIT) &&  sync_key && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      key_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!sync_key) begin
            state <= S_PRESS_WAIT;
            cnt   <= '0;
          end
        end
        S_PRESS_WAIT: begin
          if (sync_key) begin
            state <= S_IDLE;
          end else if (accept_press) begin
            state       <= S_DOWN;
            press_pulse <= 1'b1;
            key_level   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DOWN: begin
          if (sync_key) begin
            state <= S_RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        S_RELEASE_WAIT: begin
          if (!sync_key) begin
            state <= S_DOWN;
          end else if (accept_release) begin
            state         <= S_IDLE;
            release_pulse <= 1'b1;
            key_level     <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef KEY_LONG_PRESS_EN
  localparam int LONG_W = $clog2(LONG_CYCLES + 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);

  logic [LONG_W-1:0] long_cnt;
  logic              held;

  assign held = (state == S_DOWN) || (state == S_RELEASE_WAIT);

  // Counter saturates one past the firing point, so a long hold pulses exactly once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_cnt   <= '0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= 1'b0;
      if (accept_press) begin
        long_cnt <= '0;
      end else if (held) begin
        if (long_cnt == LONG_LAST) begin
          long_pulse <= 1'b1;
        end
        if (long_cnt != LONG_MAX) begin
          long_cnt <= long_cnt + LONG_W'(1);
        end
      end else begin
        long_cnt <= '0;
      end
    end
  end
`else
  assign long_pulse = 1'b0;
`endif

endmodule

module key_debounce_multi #(
  parameter int NUM_KEYS    = 4,
  parameter int DB_CYCLES   = 1_000_000,
  parameter int LONG_CYCLES = 50_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] long_pulse,
  output logic                key_any
);

  // An illegal parameter set builds no channels, so it shows up as dead keys
  // rather than as counters of nonsensical width.
  localparam bit PARAMS_OK = (NUM_KEYS >= 1) && (DB_CYCLES >= 2) && (LONG_CYCLES > DB_CYCLES);

  generate
    if (PARAMS_OK) begin : g_keys
      for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        key_debounce_chan #(
          .DB_CYCLES   (DB_CYCLES)
`ifdef KEY_LONG_PRESS_EN
          , .LONG_CYCLES (LONG_CYCLES)
`endif
        ) u_chan (
          .clk           (clk),
          .rst_n         (rst_n),
          .key_n         (key_n[i]),
          .key_level     (key_level[i]),
          .press_pulse   (press_pulse[i]),
          .release_pulse (release_pulse[i]),
          .long_pulse    (long_pulse[i])
        );
      end
    end else begin : g_no_keys
      assign key_level     = '0;
      assign press_pulse   = '0;
      assign release_pulse = '0;
      assign long_pulse    = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_any <= 1'b0;
    end else begin
      key_any <= |key_level;
    end
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Scoreboard bench for key_debounce_multi: per-cycle expected output vectors are queued
// from the stimulus timing and compared on the falling clock edge.

module tb_key_debounce_multi;

  localparam int NUM_KEYS    = 2;
  localparam int DB_CYCLES   = 4;
  localparam int LONG_CYCLES = 16;
  localparam int LAT         = DB_CYCLES + 2;
`ifdef KEY_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NUM_KEYS-1:0] key_n = '1;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] press_pulse;
  logic [NUM_KEYS-1:0] release_pulse;
  logic [NUM_KEYS-1:0] long_pulse;
  logic                key_any;

  int checks = 0;
  int failures = 0;

  // Vector layout: {press[1:0], release[1:0], long[1:0], level[1:0], any}
  logic [8:0]          exp_arr [64];
  logic [NUM_KEYS-1:0] stim    [64];
  logic [8:0]          exp_q   [$];

  key_debounce_multi #(
    .NUM_KEYS    (NUM_KEYS),
    .DB_CYCLES   (DB_CYCLES),
    .LONG_CYCLES (LONG_CYCLES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_n         (key_n),
    .key_level     (key_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .key_any       (key_any)
  );

  always #10 clk = ~clk;

  function automatic logic [8:0] observed();
    return {press_pulse, release_pulse, long_pulse, key_level, key_any};
  endfunction

  task automatic clear_scenario();
    for (int i = 0; i < 64; i++) begin
      exp_arr[i] = '0;
      stim[i]    = '1;
    end
  endtask

  // Key ch driven low from tick t0 and back high from tick r0.
  task automatic add_press(input int ch, input int t0, input int r0);
    exp_arr[t0 + LAT][7 + ch] = 1'b1;
    for (int t = t0 + LAT; t < r0 + LAT; t++) exp_arr[t][1 + ch] = 1'b1;
    for (int t = t0 + LAT + 1; t <= r0 + LAT; t++) exp_arr[t][0] = 1'b1;
    exp_arr[r0 + LAT][5 + ch] = 1'b1;
    if (LONG_EN && (t0 + LAT + LONG_CYCLES < r0 + LAT))
      exp_arr[t0 + LAT + LONG_CYCLES][3 + ch] = 1'b1;
    for (int t = t0; t < r0; t++) stim[t][ch] = 1'b0;
  endtask

  task automatic push_expected(input int len);
    for (int i = 0; i < len; i++) exp_q.push_back(exp_arr[i]);
  endtask

  task automatic test_reset();
    logic [8:0] got;
    rst_n = 1'b0;
    key_n = '1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      got = observed();
      checks++;
      if (got !== 9'd0) begin
        failures++;
        $display("[TB] FAIL reset_hold t=%0d got=%b exp=%b", t, got, 9'd0);
      end
    end
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      got = observed();
      checks++;
      if (got !== 9'd0) begin
        failures++;
        $display("[TB] FAIL reset_idle t=%0d got=%b exp=%b", t, got, 9'd0);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [8:0] got, want;
    clear_scenario();
    add_press(0, 0, 10);
    push_expected(20);
    for (int t = 0; t < 20; t++) begin
      key_n = stim[t];
      @(negedge clk);
      got  = observed();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("[TB] FAIL clean_press t=%0d got=%b exp=%b", t, got, want);
      end
    end
  endtask

  task automatic test_bounce();
    logic [8:0] got, want;
    clear_scenario();
    stim[0] = 2'b10; stim[1] = 2'b10; stim[2] = 2'b11;
    stim[3] = 2'b10; stim[4] = 2'b10;
    push_expected(12);
    for (int t = 0; t < 12; t++) begin
      key_n = stim[t];
      @(negedge clk);
      got  = observed();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("[TB] FAIL bounce t=%0d got=%b exp=%b", t, got, want);
      end
    end
  endtask

  task automatic test_long_press();
    logic [8:0] got, want;
    clear_scenario();
    add_press(1, 0, 30);
    push_expected(40);
    for (int t = 0; t < 40; t++) begin
      key_n = stim[t];
      @(negedge clk);
      got  = observed();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("[TB] FAIL long_press t=%0d got=%b exp=%b", t, got, want);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [8:0] got, want;
    clear_scenario();
    add_press(0, 0, 8);
    add_press(1, 0, 8);
    push_expected(18);
    for (int t = 0; t < 18; t++) begin
      key_n = stim[t];
      @(negedge clk);
      got  = observed();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("[TB] FAIL simultaneous t=%0d got=%b exp=%b", t, got, want);
      end
    end
  endtask

  task automatic test_reset_midpress();
    logic [8:0] got, want;
    clear_scenario();
    exp_arr[LAT][7] = 1'b1;
    for (int t = LAT; t < 10; t++) exp_arr[t][1] = 1'b1;
    for (int t = LAT + 1; t < 10; t++) exp_arr[t][0] = 1'b1;
    for (int t = 0; t < 11; t++) stim[t][0] = 1'b0;
    add_press(0, 11, 25);
    push_expected(36);
    for (int t = 0; t < 36; t++) begin
      key_n = stim[t];
      if (t == 10) begin
        rst_n = 1'b0;
        #1;
        got = observed();
        checks++;
        if (got !== 9'd0) begin
          failures++;
          $display("[TB] FAIL reset_immediate got=%b exp=%b", got, 9'd0);
        end
      end
      if (t == 11) rst_n = 1'b1;
      @(negedge clk);
      got  = observed();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("[TB] FAIL reset_midpress t=%0d got=%b exp=%b", t, got, want);
      end
    end
  endtask

  initial begin
    $display("[TB] key_debounce_multi bench, long-press build=%0d", LONG_EN);
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_simultaneous();
    test_reset_midpress();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
